// File: rtl/deco_pkg.sv
// Shared types and constants for the turbo-decoder frame receiver.
package deco_pkg;

  localparam int unsigned DECO_DATA_W = 21;
  localparam int unsigned DECO_WORDS  = 4;
  localparam int unsigned DECO_OUT_W  = 5;

  localparam int unsigned ERR_SHORT   = 0;
  localparam int unsigned ERR_TIMEOUT = 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ISSUE,
    WAIT,
    DONE
  } deco_rx_state_t;

endpackage

// File: rtl/deco_frame_rx_if.sv
// Host beat handshake and decoder-core launch/result signals of deco_frame_rx.
interface deco_frame_rx_if #(
  parameter int unsigned DATA_W = deco_pkg::DECO_DATA_W,
  parameter int unsigned WORDS  = deco_pkg::DECO_WORDS,
  parameter int unsigned OUT_W  = deco_pkg::DECO_OUT_W
) ();

  logic                    start_i;
  logic [DATA_W-1:0]       data_i;
  logic [OUT_W-1:0]        data_o;
  logic                    done_o;
  logic [DATA_W*WORDS-1:0] core_frame_o;
  logic                    core_start_o;
  logic [OUT_W-1:0]        core_data_i;
  logic                    core_done_i;

  modport slave (
    input  start_i, data_i, core_data_i, core_done_i,
    output data_o, done_o, core_frame_o, core_start_o
  );

  modport master (
    output start_i, data_i, core_data_i, core_done_i,
    input  data_o, done_o, core_frame_o, core_start_o
  );

endinterface

// File: rtl/deco_rx_watchdog.sv
// WAIT-state watchdog: clear/enable counter that flags expiry after TIMEOUT cycles.
// Only built when DECO_RX_TIMEOUT_EN is defined.
`ifdef DECO_RX_TIMEOUT_EN
module deco_rx_watchdog #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk_p_i,
  input  logic reset_n_i,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire_c
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] r_cnt;

  // Expiry lands on the TIMEOUT-th enabled cycle.
  assign o_expire_c = i_en && (r_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk_p_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_expire_c) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule
`endif

// File: rtl/deco_frame_rx.sv
// Frame receiver/sequencer: assembles WORDS host beats, launches the decoder core, returns its result.
// Optional core watchdog enabled by defining DECO_RX_TIMEOUT_EN.
module deco_frame_rx
  import deco_pkg::*;
#(
  parameter int unsigned DATA_W  = DECO_DATA_W,
  parameter int unsigned WORDS   = DECO_WORDS,
  parameter int unsigned OUT_W   = DECO_OUT_W,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                 clk_p_i,
  input  logic                 reset_n_i,
  deco_frame_rx_if.slave       bus,
  input  logic                 err_clr_i,
  output logic [15:0]          frame_cnt_o,
  output logic [1:0]           err_o
);

  localparam int unsigned FRAME_W = DATA_W * WORDS;
  localparam int unsigned CNT_W   = (WORDS > 1) ? $clog2(WORDS) : 1;

  deco_rx_state_t     r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [FRAME_W-1:0] r_beats;
  logic [FRAME_W-1:0] r_frame;
  logic [OUT_W-1:0]   r_data;
  logic               r_done;
  logic               r_core_start;
  logic [15:0]        r_frame_cnt;
  logic [1:0]         r_err;

  logic [CNT_W-1:0]   w_idx;
  logic               w_last;
  logic [FRAME_W-1:0] w_beats_nxt;
  logic [1:0]         w_err_set;
  logic               w_expire;

  assign bus.data_o       = r_data;
  assign bus.done_o       = r_done;
  assign bus.core_frame_o = r_frame;
  assign bus.core_start_o = r_core_start;
  assign frame_cnt_o      = r_frame_cnt;
  assign err_o            = r_err;

`ifdef DECO_RX_TIMEOUT_EN
  deco_rx_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk_p_i    (clk_p_i),
    .reset_n_i  (reset_n_i),
    .i_clr      (r_state != WAIT),
    .i_en       (r_state == WAIT),
    .o_expire_c (w_expire)
  );
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT != 0);
  assign w_expire         = 1'b0;
`endif

  // Beat staging: frame output only updates once the last beat arrives, so short frames leave it intact.
  always_comb begin
    w_idx       = (r_state == LOAD) ? r_cnt : '0;
    w_last      = (w_idx == CNT_W'(WORDS - 1));
    w_beats_nxt = r_beats;
    w_beats_nxt[32'(w_idx) * DATA_W +: DATA_W] = bus.data_i;
  end

  always_comb begin
    w_err_set = '0;
    if (r_state == LOAD && !bus.start_i) begin
      w_err_set[ERR_SHORT] = 1'b1;
    end
    if (r_state == WAIT && !bus.core_done_i && w_expire) begin
      w_err_set[ERR_TIMEOUT] = 1'b1;
    end
  end

  always_ff @(posedge clk_p_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_beats      <= '0;
      r_frame      <= '0;
      r_data       <= '0;
      r_done       <= 1'b0;
      r_core_start <= 1'b0;
      r_frame_cnt  <= '0;
      r_err        <= '0;
    end else begin
      r_core_start <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= (err_clr_i ? 2'b00 : r_err) | w_err_set;

      case (r_state)
        IDLE, LOAD: begin
          if (bus.start_i) begin
            r_beats <= w_beats_nxt;
            r_cnt   <= w_idx + CNT_W'(1);
            if (w_last) begin
              r_frame      <= w_beats_nxt;
              r_core_start <= 1'b1;
              r_state      <= ISSUE;
            end else begin
              r_state <= LOAD;
            end
          end else begin
            r_state <= IDLE;
          end
        end
        ISSUE: r_state <= WAIT;
        WAIT: begin
          // A core result in the expiry cycle wins over the timeout.
          if (bus.core_done_i) begin
            r_data      <= bus.core_data_i;
            r_done      <= 1'b1;
            r_frame_cnt <= r_frame_cnt + 16'd1;
            r_state     <= DONE;
          end else if (w_expire) begin
            r_data      <= '0;
            r_done      <= 1'b1;
            r_frame_cnt <= r_frame_cnt + 16'd1;
            r_state     <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_deco_frame_rx.sv
// Directed, table-driven bench for deco_frame_rx (default 4x21-bit build plus a 1x84-bit instance).
// Define DECO_RX_TIMEOUT_EN to also exercise the watchdog with TIMEOUT=8.
module tb_deco_frame_rx;

  typedef struct packed {
    logic [20:0] b0;
    logic [20:0] b1;
    logic [20:0] b2;
    logic [20:0] b3;
    logic [4:0]  res;
    logic [83:0] frame;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        err_clr;
  logic [15:0] frame_cnt;
  logic [1:0]  err;
  logic [15:0] frame_cnt1;
  logic [1:0]  err1;

  int n_chk;
  int n_err;

  deco_frame_rx_if #(.DATA_W(21), .WORDS(4), .OUT_W(5)) bus ();
  deco_frame_rx_if #(.DATA_W(84), .WORDS(1), .OUT_W(8)) bus1 ();

  deco_frame_rx #(
    .DATA_W(21), .WORDS(4), .OUT_W(5), .TIMEOUT(8)
  ) u_dut (
    .clk_p_i     (clk),
    .reset_n_i   (rst_n),
    .bus         (bus),
    .err_clr_i   (err_clr),
    .frame_cnt_o (frame_cnt),
    .err_o       (err)
  );

  deco_frame_rx #(
    .DATA_W(84), .WORDS(1), .OUT_W(8), .TIMEOUT(8)
  ) u_dut1 (
    .clk_p_i     (clk),
    .reset_n_i   (rst_n),
    .bus         (bus1),
    .err_clr_i   (1'b0),
    .frame_cnt_o (frame_cnt1),
    .err_o       (err1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.start_i      = 1'b0;
    bus.data_i       = '0;
    bus.core_data_i  = '0;
    bus.core_done_i  = 1'b0;
    bus1.start_i     = 1'b0;
    bus1.data_i      = '0;
    bus1.core_data_i = '0;
    bus1.core_done_i = 1'b0;
    err_clr          = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One frame on the 4-beat instance with a core answering lat cycles into WAIT.
  task automatic run_frame(input vec_t v, input int lat, input logic [15:0] exp_cnt);
    logic [20:0] beats [4];
    beats[0] = v.b0;
    beats[1] = v.b1;
    beats[2] = v.b2;
    beats[3] = v.b3;
    bus.start_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.data_i = beats[k];
      @(negedge clk);
      if (k == 2) chk("core_start_early", 128'(bus.core_start_o), 128'(0));
    end
    chk("core_start_pulse", 128'(bus.core_start_o), 128'(1));
    chk("core_frame", 128'(bus.core_frame_o), 128'(v.frame));
    @(negedge clk);
    chk("core_start_width", 128'(bus.core_start_o), 128'(0));
    repeat (lat - 1) @(negedge clk);
    bus.core_done_i = 1'b1;
    bus.core_data_i = v.res;
    @(negedge clk);
    bus.core_done_i = 1'b0;
    bus.start_i     = 1'b0;
    chk("done_o", 128'(bus.done_o), 128'(1));
    chk("data_o", 128'(bus.data_o), 128'(v.res));
    chk("frame_cnt", 128'(frame_cnt), 128'(exp_cnt));
    @(negedge clk);
    chk("done_width", 128'(bus.done_o), 128'(0));
  endtask

  vec_t        vecs [4];
  vec_t        v;
  logic [83:0] wide [2];
  logic [7:0]  wres [2];

  initial begin
    n_chk = 0;
    n_err = 0;
    idle_inputs();
    rst_n = 1'b0;

    vecs[0] = '{21'h00001, 21'h00002, 21'h00003, 21'h00004, 5'b10110,
                {21'h00004, 21'h00003, 21'h00002, 21'h00001}};
    vecs[1] = '{21'h1FFFFF, 21'h00000, 21'h1FFFFF, 21'h00000, 5'b11111,
                {21'h00000, 21'h1FFFFF, 21'h00000, 21'h1FFFFF}};
    vecs[2] = '{21'h00000, 21'h00000, 21'h00000, 21'h00000, 5'b00001,
                {21'h00000, 21'h00000, 21'h00000, 21'h00000}};
    vecs[3] = '{21'h12345, 21'hABCDE, 21'h1F0F0, 21'h00F0F, 5'b01010,
                {21'h00F0F, 21'h1F0F0, 21'hABCDE, 21'h12345}};
    wide[0] = 84'h123456789ABCDEF012345;
    wide[1] = 84'hFEDCBA9876543210FEDCB;
    wres[0] = 8'hA5;
    wres[1] = 8'h3C;

    repeat (2) @(negedge clk);
    chk("rst_data_o", 128'(bus.data_o), 128'(0));
    chk("rst_done_o", 128'(bus.done_o), 128'(0));
    chk("rst_core_frame", 128'(bus.core_frame_o), 128'(0));
    chk("rst_core_start", 128'(bus.core_start_o), 128'(0));
    chk("rst_frame_cnt", 128'(frame_cnt), 128'(0));
    chk("rst_err", 128'(err), 128'(0));
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      run_frame(vecs[i], 2, 16'(i + 1));
    end

    // Short frame: two beats then start drops.
    bus.start_i = 1'b1;
    bus.data_i  = 21'h1AAAA;
    @(negedge clk);
    bus.data_i  = 21'h0BBBB;
    @(negedge clk);
    chk("short_no_start", 128'(bus.core_start_o), 128'(0));
    bus.start_i = 1'b0;
    @(negedge clk);
    chk("short_err", 128'(err), 128'(2'b01));
    chk("short_no_done", 128'(bus.done_o), 128'(0));
    chk("short_frame_kept", 128'(bus.core_frame_o), 128'(vecs[3].frame));
    @(negedge clk);
    chk("short_no_start2", 128'(bus.core_start_o), 128'(0));
    chk("short_cnt", 128'(frame_cnt), 128'(4));
    run_frame(vecs[0], 1, 16'd5);
    chk("err_sticky", 128'(err), 128'(2'b01));
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_cleared", 128'(err), 128'(2'b00));

    // New short-frame error in the same cycle as the clear must stay set.
    bus.start_i = 1'b1;
    bus.data_i  = 21'h00777;
    @(negedge clk);
    bus.start_i = 1'b0;
    err_clr     = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_set_wins", 128'(err), 128'(2'b01));
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_cleared2", 128'(err), 128'(2'b00));

    // Back-to-back frames at minimum host gap, core latency 3.
    do_reset();
    for (int f = 0; f < 160; f++) begin
      v.b0    = 21'(f * 37 + 1) ^ 21'h15A5A;
      v.b1    = 21'(f * 37 + 6) ^ 21'h0C3C3;
      v.b2    = 21'(f * 37 + 11) ^ 21'h1E1E1;
      v.b3    = 21'(f * 37 + 16) ^ 21'h07777;
      v.res   = 5'(f * 7 + 3);
      v.frame = {v.b3, v.b2, v.b1, v.b0};
      run_frame(v, 3, 16'(f + 1));
    end
    chk("b2b_frame_cnt", 128'(frame_cnt), 128'(160));

    // Asynchronous reset while in LOAD at beat 2.
    bus.start_i = 1'b1;
    bus.data_i  = 21'h11111;
    @(negedge clk);
    bus.data_i  = 21'h22222;
    @(negedge clk);
    bus.data_i  = 21'h33333;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_data_o", 128'(bus.data_o), 128'(0));
    chk("arst_done_o", 128'(bus.done_o), 128'(0));
    chk("arst_core_frame", 128'(bus.core_frame_o), 128'(0));
    chk("arst_core_start", 128'(bus.core_start_o), 128'(0));
    chk("arst_frame_cnt", 128'(frame_cnt), 128'(0));
    chk("arst_err", 128'(err), 128'(0));
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_frame(vecs[3], 2, 16'd1);
    chk("arst_no_err", 128'(err), 128'(0));

    // Single-beat 84-bit instance: launch on the cycle after the beat.
    for (int f = 0; f < 2; f++) begin
      bus1.start_i = 1'b1;
      bus1.data_i  = wide[f];
      @(negedge clk);
      chk("w1_core_start", 128'(bus1.core_start_o), 128'(1));
      chk("w1_core_frame", 128'(bus1.core_frame_o), 128'(wide[f]));
      @(negedge clk);
      chk("w1_core_start_width", 128'(bus1.core_start_o), 128'(0));
      bus1.core_done_i = 1'b1;
      bus1.core_data_i = wres[f];
      @(negedge clk);
      bus1.core_done_i = 1'b0;
      bus1.start_i     = 1'b0;
      chk("w1_done_o", 128'(bus1.done_o), 128'(1));
      chk("w1_data_o", 128'(bus1.data_o), 128'(wres[f]));
      chk("w1_frame_cnt", 128'(frame_cnt1), 128'(f + 1));
      @(negedge clk);
      chk("w1_done_width", 128'(bus1.done_o), 128'(0));
    end
    chk("w1_err", 128'(err1), 128'(0));

`ifdef DECO_RX_TIMEOUT_EN
    // Silent core: done_o on the 9th cycle after core_start_o, data 0, timeout error.
    bus.start_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.data_i = 21'(k + 40);
      @(negedge clk);
    end
    chk("to_core_start", 128'(bus.core_start_o), 128'(1));
    repeat (8) @(negedge clk);
    chk("to_not_yet", 128'(bus.done_o), 128'(0));
    @(negedge clk);
    bus.start_i = 1'b0;
    chk("to_done", 128'(bus.done_o), 128'(1));
    chk("to_data_zero", 128'(bus.data_o), 128'(0));
    chk("to_err", 128'(err), 128'(2'b10));
    chk("to_cnt", 128'(frame_cnt), 128'(2));
    @(negedge clk);
    chk("to_done_width", 128'(bus.done_o), 128'(0));
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;

    // Core answers on the expiry cycle: result wins, no error.
    bus.start_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.data_i = 21'(k + 50);
      @(negedge clk);
    end
    chk("to2_core_start", 128'(bus.core_start_o), 128'(1));
    repeat (8) @(negedge clk);
    bus.core_done_i = 1'b1;
    bus.core_data_i = 5'b01101;
    @(negedge clk);
    bus.core_done_i = 1'b0;
    bus.start_i     = 1'b0;
    chk("to2_done", 128'(bus.done_o), 128'(1));
    chk("to2_data", 128'(bus.data_o), 128'(5'b01101));
    chk("to2_no_err", 128'(err), 128'(2'b00));
    chk("to2_cnt", 128'(frame_cnt), 128'(3));
    @(negedge clk);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
